// File: rtl/klavye_pkg.sv
// Shared types and defaults for the keyboard lock controller.
package klavye_pkg;

  localparam int unsigned BAYT_W                  = 8;
  localparam int unsigned VARSAYILAN_CEZA1        = 10;
  localparam int unsigned VARSAYILAN_CEZA2        = 25;
  localparam int unsigned VARSAYILAN_GUVENLI_SURE = 100;

  typedef enum logic [1:0] {
    DINLE   = 2'd0,
    GUVENLI = 2'd1,
    KILITLI = 2'd2,
    KALICI  = 2'd3
  } durum_t;

  // Failure counter increment, saturating at two.
  function automatic logic [1:0] sayi_artir(input logic [1:0] sayi);
    return (sayi == 2'd2) ? 2'd2 : 2'(sayi + 2'd1);
  endfunction

endpackage

// File: rtl/sifre_kaydirici.sv
// Password register with byte-wise load, character history shifter and
// a comparator that includes the character currently being presented.
module sifre_kaydirici
  import klavye_pkg::*;
#(
  parameter int unsigned SIFRE_UZUNLUK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              yukle,
  input  logic [BAYT_W-1:0] yuk_bayt,
  input  logic              kaydir,
  input  logic              temizle,
  input  logic [BAYT_W-1:0] karakter,
  output logic              sifre_gecerli,
  output logic              eslesme_c
);

  localparam int unsigned SIFRE_BIT  = SIFRE_UZUNLUK * BAYT_W;
  localparam int unsigned GECMIS_BIT = (SIFRE_UZUNLUK - 1) * BAYT_W;
  localparam int unsigned IDX_W      = $clog2(SIFRE_UZUNLUK);

  logic [SIFRE_BIT-1:0]  sifre;
  logic [GECMIS_BIT-1:0] gecmis;
  logic [IDX_W-1:0]      yuk_idx;
  logic [SIFRE_BIT-1:0]  aday_c;

  // Only the last L-1 characters are kept; the live character completes the window.
  assign aday_c    = {gecmis, karakter};
  assign eslesme_c = sifre_gecerli && (aday_c == sifre);

  // Slot 0 is the most significant byte of the password.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sifre         <= '0;
      yuk_idx       <= '0;
      sifre_gecerli <= 1'b0;
    end else if (yukle) begin
      for (int unsigned i = 0; i < SIFRE_UZUNLUK; i++) begin
        if (yuk_idx == IDX_W'(i)) begin
          sifre[(SIFRE_UZUNLUK-1-i)*BAYT_W +: BAYT_W] <= yuk_bayt;
        end
      end
      if (yuk_idx == IDX_W'(SIFRE_UZUNLUK - 1)) begin
        yuk_idx       <= '0;
        sifre_gecerli <= 1'b1;
      end else begin
        yuk_idx       <= IDX_W'(yuk_idx + 1'b1);
        sifre_gecerli <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gecmis <= '0;
    end else if (temizle) begin
      gecmis <= '0;
    end else if (kaydir) begin
      gecmis <= GECMIS_BIT'(aday_c);
    end
  end

endmodule

// File: rtl/klavye_kilit_denetleyici.sv
// Keyboard password listener: grants a timed safe window on match and
// escalates failed attempts into temporary and finally permanent lockout.
module klavye_kilit_denetleyici
  import klavye_pkg::*;
#(
  parameter int unsigned SIFRE_UZUNLUK   = 4,
  parameter int unsigned DENEME_KARAKTER = 8,
  parameter int unsigned GUVENLI_SURE    = VARSAYILAN_GUVENLI_SURE,
  parameter int unsigned CEZA_W          = 8,
  parameter int unsigned CEZA1           = VARSAYILAN_CEZA1,
  parameter int unsigned CEZA2           = VARSAYILAN_CEZA2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              karakter_aktif,
  input  logic [BAYT_W-1:0] karakter,
  input  logic              sifre_degis,
  input  logic [BAYT_W-1:0] sifre_kanali,
  output logic              guvenli,
  output logic              kitle,
  output logic [CEZA_W-1:0] ceza,
  output logic              sifre_gecerli,
  output logic [1:0]        ceza_sayisi
);

  localparam int unsigned SAYAC_W  = $clog2(GUVENLI_SURE + 1);
  localparam int unsigned DENEME_W = $clog2(DENEME_KARAKTER + 1);

  durum_t              durum;
  logic [SAYAC_W-1:0]  zamanlayici;
  logic [DENEME_W-1:0] deneme;

  logic yukle_c;
  logic kar_kabul_c;
  logic esles_ham_c;
  logic esles_c;
  logic sayilan_c;
  logic tukendi_c;
  logic guvenli_bitti_c;
  logic kilit_bitti_c;

  // Password bytes win over a simultaneous character, which is dropped.
  assign yukle_c         = sifre_degis &&
                           ((durum == GUVENLI) || ((durum == DINLE) && !sifre_gecerli));
  assign kar_kabul_c     = karakter_aktif && ((durum == DINLE) || (durum == GUVENLI)) && !yukle_c;
  assign esles_c         = kar_kabul_c && esles_ham_c;
  assign sayilan_c       = kar_kabul_c && sifre_gecerli && (durum == DINLE);
  assign tukendi_c       = sayilan_c && (deneme == DENEME_W'(DENEME_KARAKTER - 1));
  assign guvenli_bitti_c = (durum == GUVENLI) && !esles_c && (zamanlayici == SAYAC_W'(1));
  assign kilit_bitti_c   = (durum == KILITLI) && (ceza == CEZA_W'(1));

  sifre_kaydirici #(
    .SIFRE_UZUNLUK(SIFRE_UZUNLUK)
  ) u_sifre_kaydirici (
    .clk          (clk),
    .rst          (rst),
    .yukle        (yukle_c),
    .yuk_bayt     (sifre_kanali),
    .kaydir       (kar_kabul_c),
    .temizle      (guvenli_bitti_c || kilit_bitti_c),
    .karakter     (karakter),
    .sifre_gecerli(sifre_gecerli),
    .eslesme_c    (esles_ham_c)
  );

  // Mode FSM with its timers; all status outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum       <= DINLE;
      guvenli     <= 1'b0;
      kitle       <= 1'b0;
      ceza        <= '0;
      ceza_sayisi <= 2'd0;
      zamanlayici <= '0;
      deneme      <= '0;
    end else begin
      case (durum)
        DINLE: begin
          if (esles_c) begin
            // A match on the attempt's last character still wins.
            durum       <= GUVENLI;
            guvenli     <= 1'b1;
            zamanlayici <= SAYAC_W'(GUVENLI_SURE);
            ceza_sayisi <= 2'd0;
            deneme      <= '0;
          end else if (tukendi_c) begin
            deneme      <= '0;
            kitle       <= 1'b1;
            ceza_sayisi <= sayi_artir(ceza_sayisi);
            if (ceza_sayisi == 2'd0) begin
              durum <= KILITLI;
              ceza  <= CEZA_W'(CEZA1);
            end else if (ceza_sayisi == 2'd1) begin
              durum <= KILITLI;
              ceza  <= CEZA_W'(CEZA2);
            end else begin
              durum <= KALICI;
              ceza  <= '1;
            end
          end else if (sayilan_c) begin
            deneme <= DENEME_W'(deneme + 1'b1);
          end
        end
        GUVENLI: begin
          if (esles_c) begin
            zamanlayici <= SAYAC_W'(GUVENLI_SURE);
            ceza_sayisi <= 2'd0;
          end else if (guvenli_bitti_c) begin
            durum       <= DINLE;
            guvenli     <= 1'b0;
            zamanlayici <= '0;
            deneme      <= '0;
          end else begin
            zamanlayici <= SAYAC_W'(zamanlayici - 1'b1);
          end
        end
        KILITLI: begin
          if (kilit_bitti_c) begin
            durum  <= DINLE;
            kitle  <= 1'b0;
            ceza   <= '0;
            deneme <= '0;
          end else begin
            ceza <= CEZA_W'(ceza - 1'b1);
          end
        end
        KALICI: begin
          kitle <= 1'b1;
          ceza  <= '1;
        end
        default: begin
          durum <= DINLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_klavye_kilit_denetleyici.sv
// Bench for the keyboard lock controller: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_klavye_kilit_denetleyici;

  localparam int M_LISTEN = 0;
  localparam int M_SAFE   = 1;
  localparam int M_LOCK   = 2;
  localparam int M_PERM   = 3;

  typedef struct {
    int               mode;
    logic [15:0][7:0] pw;
    int               yidx;
    bit               valid;
    logic [15:0][7:0] hist;   // hist[0] is the most recent accepted character
    int               att;
    int               fails;
    int               tmr;
    int               cz;
  } mdl_t;

  logic       clk;
  logic       rst;
  logic       ka, sd, ka2, sd2;
  logic [7:0] k, sk, k2, sk2;
  logic       guvenli, kitle, sifre_gecerli;
  logic [7:0] ceza;
  logic [1:0] ceza_sayisi;
  logic       guvenli2, kitle2, sifre_gecerli2;
  logic [3:0] ceza2;
  logic [1:0] ceza_sayisi2;

  int   checks   = 0;
  int   failures = 0;
  mdl_t ma, mb;

  klavye_kilit_denetleyici dut_a (
    .clk(clk), .rst(rst), .karakter_aktif(ka), .karakter(k),
    .sifre_degis(sd), .sifre_kanali(sk), .guvenli(guvenli), .kitle(kitle),
    .ceza(ceza), .sifre_gecerli(sifre_gecerli), .ceza_sayisi(ceza_sayisi)
  );

  klavye_kilit_denetleyici #(
    .SIFRE_UZUNLUK(2), .DENEME_KARAKTER(4), .GUVENLI_SURE(3),
    .CEZA_W(4), .CEZA1(2), .CEZA2(3)
  ) dut_b (
    .clk(clk), .rst(rst), .karakter_aktif(ka2), .karakter(k2),
    .sifre_degis(sd2), .sifre_kanali(sk2), .guvenli(guvenli2), .kitle(kitle2),
    .ceza(ceza2), .sifre_gecerli(sifre_gecerli2), .ceza_sayisi(ceza_sayisi2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = M_LISTEN; r.pw = '0; r.yidx = 0; r.valid = 1'b0; r.hist = '0;
    r.att = 0; r.fails = 0; r.tmr = 0; r.cz = 0;
    return r;
  endfunction

  // One clock of the behaviour as stated: loads, history, attempts, timers.
  function automatic mdl_t mstep(input mdl_t m, input logic cka, input logic [7:0] ck,
                                 input logic csd, input logic [7:0] csk,
                                 input int L, input int D, input int S,
                                 input int C1, input int C2);
    mdl_t n;
    bit   open, load, chr, match;
    n     = m;
    open  = (m.mode == M_LISTEN) || (m.mode == M_SAFE);
    load  = csd && ((m.mode == M_SAFE) || ((m.mode == M_LISTEN) && !m.valid));
    chr   = cka && open && !load;
    match = chr && m.valid && (ck == m.pw[L-1]);
    for (int j = 1; j < L; j++)
      if (m.hist[j-1] != m.pw[L-1-j]) match = 1'b0;
    if (load) begin
      n.pw[m.yidx] = csk;
      if (m.yidx == L - 1) begin n.yidx = 0; n.valid = 1'b1; end
      else begin n.yidx = m.yidx + 1; n.valid = 1'b0; end
    end
    if (chr) begin
      for (int j = 15; j > 0; j--) n.hist[j] = m.hist[j-1];
      n.hist[0] = ck;
    end
    case (m.mode)
      M_LISTEN: begin
        if (match) begin
          n.mode = M_SAFE; n.tmr = S; n.fails = 0; n.att = 0;
        end else if (chr && m.valid) begin
          n.att = m.att + 1;
          if (n.att == D) begin
            n.att = 0;
            if (m.fails == 0) begin n.mode = M_LOCK; n.cz = C1; end
            else if (m.fails == 1) begin n.mode = M_LOCK; n.cz = C2; end
            else n.mode = M_PERM;
            n.fails = (m.fails >= 2) ? 2 : m.fails + 1;
          end
        end
      end
      M_SAFE: begin
        if (match) begin n.tmr = S; n.fails = 0; end
        else if (m.tmr == 1) begin n.mode = M_LISTEN; n.hist = '0; n.att = 0; end
        else n.tmr = m.tmr - 1;
      end
      M_LOCK: begin
        if (m.cz == 1) begin n.mode = M_LISTEN; n.cz = 0; n.hist = '0; n.att = 0; end
        else n.cz = m.cz - 1;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic int mceza(input mdl_t m, input int cw);
    if (m.mode == M_PERM) return (1 << cw) - 1;
    if (m.mode == M_LOCK) return m.cz;
    return 0;
  endfunction

  initial begin
    ma = mreset();
    mb = mreset();
  end

  always @(posedge clk) begin
    if (rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, ka, k, sd, sk, 4, 8, 100, 10, 25);
      mb <= mstep(mb, ka2, k2, sd2, sk2, 2, 4, 3, 2, 3);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_guvenli", int'(guvenli), int'(ma.mode == M_SAFE));
      chk("a_kitle", int'(kitle), int'(ma.mode >= M_LOCK));
      chk("a_ceza", int'(ceza), mceza(ma, 8));
      chk("a_sifre_gecerli", int'(sifre_gecerli), int'(ma.valid));
      chk("a_ceza_sayisi", int'(ceza_sayisi), ma.fails);
      chk("b_guvenli", int'(guvenli2), int'(mb.mode == M_SAFE));
      chk("b_kitle", int'(kitle2), int'(mb.mode >= M_LOCK));
      chk("b_ceza", int'(ceza2), mceza(mb, 4));
      chk("b_sifre_gecerli", int'(sifre_gecerli2), int'(mb.valid));
      chk("b_ceza_sayisi", int'(ceza_sayisi2), mb.fails);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tip(input logic [7:0] c);
    ka = 1'b1; k = c; cyc(); ka = 1'b0;
  endtask

  task automatic yukle(input logic [7:0] b);
    sd = 1'b1; sk = b; cyc(); sd = 1'b0;
  endtask

  task automatic tip_n(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) tip(c);
  endtask

  task automatic yukle_abcd();
    yukle(8'h41); yukle(8'h42); yukle(8'h43); yukle(8'h44);
  endtask

  task automatic tip_abcd();
    tip(8'h41); tip(8'h42); tip(8'h43); tip(8'h44);
  endtask

  task automatic bekle_guvenli_bitis(input string name);
    int n;
    n = 0;
    while (guvenli && n < 300) begin n++; cyc(); end
    chk(name, int'(guvenli), 0);
  endtask

  task automatic bekle_kilit_bitis(input string name, output int n);
    n = 0;
    while (kitle && n < 300) begin n++; cyc(); end
    chk(name, int'(kitle), 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; ka = 0; sd = 0; ka2 = 0; sd2 = 0; cyc(); rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; ka = 0; sd = 0; k = 0; sk = 0; ka2 = 0; sd2 = 0; k2 = 0; sk2 = 0;
    repeat (2) cyc();
    chk("reset_guvenli", int'(guvenli), 0);
    chk("reset_kitle", int'(kitle), 0);
    chk("reset_ceza", int'(ceza), 0);
    chk("reset_gecerli", int'(sifre_gecerli), 0);
    chk("reset_sayisi", int'(ceza_sayisi), 0);
    rst = 1'b0;
    cyc();

    // Load ABCD, match, and measure the safe window.
    yukle_abcd();
    chk("load_gecerli", int'(sifre_gecerli), 1);
    tip_abcd();
    chk("match_guvenli", int'(guvenli), 1);
    chk("match_sayisi", int'(ceza_sayisi), 0);
    n = 0;
    while (guvenli && n < 300) begin n++; cyc(); end
    chk("safe_length", n, 100);

    // Three failed attempts: 10, 25, then permanent.
    tip_n(8'h5A, 8);
    chk("fail1_ceza", int'(ceza), 10);
    bekle_kilit_bitis("fail1_timeout", n);
    chk("fail1_length", n, 10);
    chk("fail1_release_ceza", int'(ceza), 0);
    tip_n(8'h5A, 8);
    chk("fail2_ceza", int'(ceza), 25);
    bekle_kilit_bitis("fail2_timeout", n);
    chk("fail2_length", n, 25);
    tip_n(8'h5A, 8);
    chk("perm_ceza", int'(ceza), 255);
    chk("perm_kitle", int'(kitle), 1);
    chk("perm_sayisi", int'(ceza_sayisi), 2);
    tip_abcd();
    repeat (20) cyc();
    chk("perm_hold_ceza", int'(ceza), 255);
    chk("perm_no_safe", int'(guvenli), 0);

    // Match on the attempt's final character beats the penalty.
    reset_pulse();
    yukle_abcd();
    tip_n(8'h5A, 8);
    chk("one_fail_ceza", int'(ceza), 10);
    bekle_kilit_bitis("one_fail_timeout", n);
    tip_n(8'h51, 3);
    tip(8'h58);
    tip_abcd();
    chk("lastchar_guvenli", int'(guvenli), 1);
    chk("lastchar_kitle", int'(kitle), 0);
    chk("lastchar_sayisi", int'(ceza_sayisi), 0);

    // Reload the password while safe; old one must stop matching.
    yukle(8'h31);
    chk("partial_gecerli", int'(sifre_gecerli), 0);
    yukle(8'h32); yukle(8'h33); yukle(8'h34);
    chk("reload_gecerli", int'(sifre_gecerli), 1);
    bekle_guvenli_bitis("reload_safe_timeout");
    tip_abcd();
    chk("old_pw_rejected", int'(guvenli), 0);
    tip(8'h31); tip(8'h32); tip(8'h33); tip(8'h34);
    chk("new_pw_accepted", int'(guvenli), 1);
    bekle_guvenli_bitis("new_pw_timeout");
    yukle(8'h55); yukle(8'h55); yukle(8'h55); yukle(8'h55);
    chk("ignored_load_gecerli", int'(sifre_gecerli), 1);
    tip(8'h31); tip(8'h32); tip(8'h33); tip(8'h34);
    chk("ignored_load_match", int'(guvenli), 1);
    bekle_guvenli_bitis("ignored_load_timeout");

    // Reset in the middle of a lock.
    tip_n(8'h5A, 8);
    n = 0;
    while (ceza != 8'd5 && n < 40) begin n++; cyc(); end
    chk("lock_reaches_5", int'(ceza), 5);
    rst = 1'b1;
    cyc();
    chk("midlock_rst_kitle", int'(kitle), 0);
    chk("midlock_rst_ceza", int'(ceza), 0);
    chk("midlock_rst_gecerli", int'(sifre_gecerli), 0);
    chk("midlock_rst_guvenli", int'(guvenli), 0);
    rst = 1'b0;
    tip_abcd();
    chk("after_rst_no_match", int'(guvenli), 0);
    chk("after_rst_no_gecerli", int'(sifre_gecerli), 0);

    // Short variant: re-match on the last safe cycle keeps the window open.
    sd2 = 1; sk2 = 8'h61; cyc(); sk2 = 8'h62; cyc(); sd2 = 0;
    chk("b_gecerli", int'(sifre_gecerli2), 1);
    ka2 = 1; k2 = 8'h61; cyc();
    k2 = 8'h62; cyc();
    n = int'(guvenli2); ka2 = 0; cyc();
    n += int'(guvenli2); ka2 = 1; k2 = 8'h61; cyc();
    n += int'(guvenli2); k2 = 8'h62; cyc();
    ka2 = 0;
    for (int i = 0; i < 10; i++) begin n += int'(guvenli2); cyc(); end
    chk("b_continuous_safe", n, 6);

    // Random traffic on both instances.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) reset_pulse();
      ka  = ($urandom_range(0, 9) < 6);
      k   = 8'(8'h41 + $urandom_range(0, 4));
      sd  = ($urandom_range(0, 9) < 2);
      sk  = 8'(8'h41 + $urandom_range(0, 3));
      ka2 = ($urandom_range(0, 9) < 6);
      k2  = 8'(8'h61 + $urandom_range(0, 2));
      sd2 = ($urandom_range(0, 9) < 1);
      sk2 = 8'(8'h61 + $urandom_range(0, 1));
      cyc();
    end
    ka = 0; sd = 0; ka2 = 0; sd2 = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
